skein_result_checker: RTL

Consumer end of the Skein-512 hashing pipeline. Takes the stream of finished 512-bit hashes from the hasher, pairs each with the nonce that produced it, and compares the top hash word against a 64-bit target. Queues winning nonces in a small FIFO for the host with a valid/ready handshake, and reports completion and overflow of a work unit.

---
 rtl/skein_result_checker.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/skein_result_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// skein_result_checker
//
// Consumer end of the Skein-512 hashing pipeline. Each accepted hash is
// tagged with a running nonce. Its top 64-bit word is then compared against
// a latched target in a two-stage pipeline. Winning nonces are queued in a
// small FIFO that the host drains over a valid/ready handshake.
//
// Parameters:
//   DEPTH        golden-nonce FIFO depth (power of two, >= 2)
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   start        one-cycle pulse that begins a work unit (sampled in IDLE)
//   start_nonce  nonce of the first hash of the unit
//   num_hashes   number of hashes in the unit
//   target       unsigned 64-bit threshold, latched on start
//   hash         512-bit hasher output; word [511:448] is compared
//   hash_valid   hash is a new result this cycle
//   nonce_out    FIFO head nonce (registered)
//   nonce_valid  FIFO non-empty (registered)
//   nonce_ready  host pops the head when nonce_valid && nonce_ready
//   busy         high while a unit is running or draining
//   done         one-cycle pulse at the end of a unit
//   overflow     sticky: a winning nonce was dropped on a full FIFO
//   hash_count   hashes checked in the current unit
// ---------------------------------------------------------------------------
module skein_result_checker #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  start_nonce,
  input  logic [31:0]  num_hashes,
  input  logic [63:0]  target,
  input  logic [511:0] hash,
  input  logic         hash_valid,
  output logic [31:0]  nonce_out,
  output logic         nonce_valid,
  input  logic         nonce_ready,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [31:0]  hash_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] nonce_ctr_r;
  logic [31:0] remaining_r;
  logic [63:0] target_r;
  logic        drain_cnt_r;

  // Compare pipeline
  logic        s1_valid_r;
  logic        s1_hi_lt_r;
  logic        s1_hi_eq_r;
  logic        s1_lo_le_r;
  logic [31:0] s1_tag_r;
  logic        s2_hit_r;
  logic [31:0] s2_tag_r;

  // Golden-nonce FIFO
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   fifo_cnt_r;

  logic          accept_s;
  logic [63:0]   word_s;
  logic          pop_s;
  logic          push_s;
  logic          full_s;
  logic          push_ok_s;
  logic          ovf_set_s;
  logic [AW:0]   cnt_next_s;
  logic [AW-1:0] rd_next_s;
  logic [31:0]   head_next_s;
  logic          unused_hash_s;

  assign word_s        = hash[511:448];
  assign unused_hash_s = ^hash[447:0];

  // Hash acceptance qualifier: only RUN consumes hasher results.
  always_comb begin
    accept_s = (state_r == ST_RUN) & hash_valid;
  end

  // Unit control FSM with registered busy/done/overflow and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      nonce_ctr_r <= 32'd0;
      remaining_r <= 32'd0;
      target_r    <= 64'd0;
      drain_cnt_r <= 1'b0;
      hash_count  <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ovf_set_s) begin
        overflow <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            nonce_ctr_r <= start_nonce;
            remaining_r <= num_hashes;
            target_r    <= target;
            hash_count  <= 32'd0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            drain_cnt_r <= 1'b0;
            state_r     <= (num_hashes == 32'd0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (hash_valid) begin
            nonce_ctr_r <= nonce_ctr_r + 32'd1;
            remaining_r <= remaining_r - 32'd1;
            hash_count  <= hash_count + 32'd1;
            if (remaining_r == 32'd1) begin
              drain_cnt_r <= 1'b0;
              state_r     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Two cycles let the last hash reach the FIFO before done.
          if (drain_cnt_r) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            drain_cnt_r <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-stage compare: split 32-bit compares, then combine into a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_hi_lt_r <= 1'b0;
      s1_hi_eq_r <= 1'b0;
      s1_lo_le_r <= 1'b0;
      s1_tag_r   <= 32'd0;
      s2_hit_r   <= 1'b0;
      s2_tag_r   <= 32'd0;
    end else begin
      s1_valid_r <= accept_s;
      s1_hi_lt_r <= word_s[63:32] <  target_r[63:32];
      s1_hi_eq_r <= word_s[63:32] == target_r[63:32];
      s1_lo_le_r <= word_s[31:0]  <= target_r[31:0];
      s1_tag_r   <= nonce_ctr_r;
      s2_hit_r   <= s1_valid_r & (s1_hi_lt_r | (s1_hi_eq_r & s1_lo_le_r));
      s2_tag_r   <= s1_tag_r;
    end
  end

  // FIFO push/pop decisions and next head/occupancy.
  always_comb begin
    pop_s       = nonce_valid & nonce_ready;
    push_s      = s2_hit_r;
    full_s      = (fifo_cnt_r == FIFO_FULL);
    // A pop frees the head slot in the same edge, so a full FIFO still accepts.
    push_ok_s   = push_s & (~full_s | pop_s);
    ovf_set_s   = push_s & full_s & ~pop_s;
    rd_next_s   = rd_ptr_r + PTR_ONE;
    cnt_next_s  = fifo_cnt_r;
    head_next_s = nonce_out;
    case ({push_ok_s, pop_s})
      2'b10:   cnt_next_s = fifo_cnt_r + CNT_ONE;
      2'b01:   cnt_next_s = fifo_cnt_r - CNT_ONE;
      default: cnt_next_s = fifo_cnt_r;
    endcase
    if (pop_s) begin
      if (fifo_cnt_r > CNT_ONE) begin
        head_next_s = mem_r[rd_next_s];
      end else if (push_ok_s) begin
        head_next_s = s2_tag_r;
      end else begin
        head_next_s = nonce_out;
      end
    end else if (push_ok_s && (fifo_cnt_r == CNT_ZERO)) begin
      head_next_s = s2_tag_r;
    end else begin
      head_next_s = nonce_out;
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= s2_tag_r;
    end
  end

  // FIFO pointers, occupancy and registered head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      nonce_valid <= 1'b0;
      nonce_out   <= 32'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      fifo_cnt_r  <= cnt_next_s;
      nonce_valid <= (cnt_next_s != CNT_ZERO);
      nonce_out   <= head_next_s;
    end
  end

endmodule
